icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter NSETS, default 16, number of direct-mapped one-word frames (power of two, 2..64).
REQ-002 SHALL have parameter TAG_W, default 32-2-log2(NSETS), tag width in bits.
REQ-003 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 imemREN  input  1  datapath fetch request.
REQ-006 imemaddr  input  32  fetch byte address; bits [1:0] ignored.
REQ-007 flush  input  1  invalidate all frames.
REQ-008 ihit  output  1  imemload valid this cycle.
REQ-009 imemload  output  32  fetched instruction word.
REQ-010 iREN  output  1  memory read request.
REQ-011 iaddr  output  32  memory word address, bits [1:0]=00.
REQ-012 iwait  input  1  memory busy; iREN & ~iwait means iload valid this cycle.
REQ-013 iload  input  32  memory read data.

Function
REQ-014 Address split SHALL be tag=[31:32-TAG_W], idx=[log2(NSETS)+1:2], offset=[1:0].
REQ-015 FSM SHALL have two states, IDLE and FETCH.
REQ-016 In IDLE, ihit SHALL be combinational: imemREN & valid[idx] & tag match; imemload = data[idx] (zero-latency hit).
REQ-017 In IDLE, imemREN & ~hit SHALL latch {imemaddr[31:2],2'b00} into miss_addr and move to FETCH next cycle.
REQ-018 In FETCH, iREN=1 and iaddr=miss_addr SHALL hold until iwait=0; ihit=0 throughout.
REQ-019 On the FETCH cycle with iwait=0, the frame at miss_addr's idx SHALL get data=iload, tag, valid=1; state returns to IDLE; requester hits the following cycle.
REQ-020 Miss latency SHALL be 1 (detect) + N (cycles until iwait=0) + 1 (hit) cycles.
REQ-021 Changing imemaddr or dropping imemREN during FETCH SHALL NOT abort or retarget the fill; fill completes for miss_addr.
REQ-022 imemREN=0 in IDLE SHALL give ihit=0 and no state change.
REQ-023 flush SHALL clear all valid bits next edge; in IDLE, ihit=0 that cycle.
REQ-024 flush during FETCH SHALL let memory complete; the filled frame SHALL NOT be marked valid.
REQ-025 A fill replaces any valid frame at that idx unconditionally (no other eviction policy).
REQ-026 iREN SHALL be 0 in IDLE; iaddr SHALL be 0 when iREN=0.

Reset
REQ-027 RST SHALL force state=IDLE, all valid=0, miss_addr=0, ihit=0, iREN=0, iaddr=0, immediately and asynchronously.
REQ-028 RST mid-FETCH SHALL drop the request; no frame written; frame data not reset (valid=0 suffices).

Configuration
REQ-029 ICACHE_STATS_EN defined: SHALL add outputs hit_count, miss_count (32 bit, wrap), incremented on IDLE ihit and on IDLE->FETCH respectively, cleared by RST, unaffected by flush.
REQ-030 ICACHE_STATS_EN undefined: no such ports or logic; all other behaviour identical.

Structure
REQ-031 cpu_types_pkg SHALL hold word_t, icachef_t (tag/idx/bytoff packed struct) and the icache state enum.
REQ-032 Counters SHALL live in sub-module icache_stats, instantiated only under ICACHE_STATS_EN.

Verification
REQ-033 Reset, imemREN=1, imemaddr=0x0000_0040 -> ihit=0, next cycle iREN=1, iaddr=0x40.
REQ-034 iwait=1 for 3 cycles then 0 with iload=0x2008_0001 -> next cycle ihit=1, imemload=0x2008_0001; total 5 cycles.
REQ-035 Fill 0x40 then fetch 0x80 (same idx, NSETS=16) -> miss, iaddr=0x80; refetch 0x40 -> miss again.
REQ-036 Mid-FETCH change imemaddr to 0x100 -> iaddr stays 0x40; after fill, 0x100 misses, 0x40 hits.
REQ-037 flush during FETCH of 0x40 -> fill completes, 0x40 misses afterwards; with ICACHE_STATS_EN, miss_count=2.
REQ-038 RST asserted mid-FETCH -> iREN=0 immediately; all prior addresses miss after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction word, default icache address layout and
// the icache controller state encoding.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Address layout for the default 16-frame instruction cache.
    localparam int ICACHE_NSETS = 16;
    localparam int ICACHE_IDX_W = 4;
    localparam int ICACHE_TAG_W = WORD_W - 2 - ICACHE_IDX_W;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_stats.sv
// Hit / miss event counters for the instruction cache. Both wrap at 2^32,
// are cleared only by RST and do not react to cache flushes.
module icache_stats
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  hit_inc,
    input  logic  miss_inc,
    output word_t hit_count,
    output word_t miss_count
);

    // Count lookup hits and miss-to-fetch transitions.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_inc)  hit_count  <= hit_count + 32'd1;
            if (miss_inc) miss_count <= miss_count + 32'd1;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a zero-latency
// hit path and a blocking single-word refill from memory.
// Optional feature macro: ICACHE_STATS_EN adds hit_count / miss_count.
//
// Memory handshake: while iREN=1 the request (iaddr) is held stable; the
// cycle in which iwait=0 is the single cycle in which iload carries the
// requested word, and the request is dropped on the following edge.
// Datapath side: ihit=1 marks the cycle in which imemload is valid.
module icache
    import cpu_types_pkg::*;
#(
    parameter int NSETS = 16,
    parameter int TAG_W = 32 - 2 - $clog2(NSETS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          imemREN,
    input  word_t         imemaddr,
    input  logic          flush,
    output logic          ihit,
    output word_t         imemload,
    output logic          iREN,
    output word_t         iaddr,
    input  logic          iwait,
    input  word_t         iload,
    output icache_state_t dbg_state
`ifdef ICACHE_STATS_EN
    ,
    output word_t         hit_count,
    output word_t         miss_count
`endif
);

    localparam int IDX_W = $clog2(NSETS);

    icache_state_t state_q, state_d;
    word_t         miss_addr_q;
    logic          flushed_q;
    logic [NSETS-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [NSETS];
    word_t            data_q [NSETS];

    logic [IDX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic             lookup_hit;
    logic             miss_start;
    logic             fill;

    assign req_idx  = imemaddr[IDX_W+1:2];
    assign req_tag  = imemaddr[31:32-TAG_W];
    assign fill_idx = miss_addr_q[IDX_W+1:2];
    assign fill_tag = miss_addr_q[31:32-TAG_W];

    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign dbg_state  = state_q;

    // Next-state and output decode; a flush in IDLE suppresses the hit.
    always_comb begin
        state_d    = state_q;
        ihit       = 1'b0;
        imemload   = data_q[req_idx];
        iREN       = 1'b0;
        iaddr      = '0;
        miss_start = 1'b0;
        fill       = 1'b0;
        case (state_q)
            IDLE: begin
                ihit = imemREN && lookup_hit && !flush;
                if (imemREN && !ihit) begin
                    miss_start = 1'b1;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = miss_addr_q;
                if (!iwait) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state, miss address, valid bits and pending-flush marker.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            flushed_q   <= 1'b0;
            valid_q     <= '0;
        end else begin
            state_q <= state_d;
            if (miss_start) miss_addr_q <= {imemaddr[31:2], 2'b00};
            // A flush seen at any point of a refill keeps that frame invalid.
            if (miss_start || fill)
                flushed_q <= 1'b0;
            else if (state_q == FETCH && flush)
                flushed_q <= 1'b1;
            if (flush)
                valid_q <= '0;
            else if (fill && !flushed_q)
                valid_q[fill_idx] <= 1'b1;
        end
    end

    // Frame payload; not reset because valid bits gate its use.
    always_ff @(posedge CLK) begin
        if (fill) begin
            data_q[fill_idx] <= iload;
            tag_q[fill_idx]  <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    icache_stats u_stats (
        .CLK        (CLK),
        .RST        (RST),
        .hit_inc    (ihit),
        .miss_inc   (miss_start),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );
`endif

endmodule

// File: tb/tb_icache.sv
// Randomised and directed bench for icache against a frame-array model.
module tb_icache;
    import cpu_types_pkg::*;

    localparam int NSETS = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          imemREN;
    word_t         imemaddr;
    logic          flush;
    logic          ihit;
    word_t         imemload;
    logic          iREN;
    word_t         iaddr;
    logic          iwait;
    word_t         iload;
    icache_state_t dbg_state;
`ifdef ICACHE_STATS_EN
    word_t         hit_count;
    word_t         miss_count;
`endif

    icache #(.NSETS(NSETS)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .flush     (flush),
        .ihit      (ihit),
        .imemload  (imemload),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload),
        .dbg_state (dbg_state)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    // Clock / reset block
    always #5 CLK = ~CLK;

    // Reference model: per-frame contents plus an outstanding-refill record.
    bit          mv [NSETS];
    logic [31:0] mt [NSETS];
    logic [31:0] md [NSETS];
    bit          mfetch;
    bit          mflushed;
    logic [31:0] maddr;
    int unsigned m_hits;
    int unsigned m_misses;

    // Expected per-cycle view: {ihit, imemload, iREN, iaddr, fetching}
    logic [66:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;

    task automatic model_reset();
        for (int i = 0; i < NSETS; i++) mv[i] = 1'b0;
        mfetch   = 1'b0;
        mflushed = 1'b0;
        maddr    = '0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Driver: applies one cycle of inputs and records what the cache owes.
    task automatic drive(input bit ren, input logic [31:0] addr, input bit fl,
                         input bit wt, input logic [31:0] ld);
        logic [66:0] e;
        int          idx;
        int          fi;
        logic [31:0] tg;
        bit          hit;
        @(posedge CLK);
        #1;
        imemREN  = ren;
        imemaddr = addr;
        flush    = fl;
        iwait    = wt;
        iload    = ld;
        idx = int'((addr >> 2) % NSETS);
        tg  = addr / (4 * NSETS);
        if (!mfetch) begin
            hit = ren && mv[idx] && (mt[idx] == tg) && !fl;
            e   = {hit, (hit ? md[idx] : 32'h0), 1'b0, 32'h0, 1'b0};
            if (hit) m_hits++;
            if (ren && !hit) begin
                mfetch   = 1'b1;
                mflushed = 1'b0;
                maddr    = addr & ~32'h3;
                m_misses++;
            end
        end else begin
            e = {1'b0, 32'h0, 1'b1, maddr, 1'b1};
            if (!wt) begin
                fi     = int'((maddr >> 2) % NSETS);
                md[fi] = ld;
                mt[fi] = maddr / (4 * NSETS);
                mv[fi] = !(mflushed || fl);
                mfetch = 1'b0;
            end else if (fl) begin
                mflushed = 1'b1;
            end
        end
        if (fl) for (int i = 0; i < NSETS; i++) mv[i] = 1'b0;
        exp_q.push_back(e);
    endtask

    // Miss on addr, wait nw cycles, then return data; leaves the cache idle.
    task automatic fetch_word(input logic [31:0] addr, input int nw, input logic [31:0] data);
        drive(1'b1, addr, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < nw; i++) drive(1'b1, addr, 1'b0, 1'b1, 32'hdead_beef);
        drive(1'b1, addr, 1'b0, 1'b0, data);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must drop at once.
    task automatic apply_reset();
        @(negedge CLK);
        #1;
        RST = 1'b1;
        #1;
        check("rst_iREN", {31'h0, iREN}, 32'h0);
        check("rst_ihit", {31'h0, ihit}, 32'h0);
        check("rst_iaddr", iaddr, 32'h0);
        check("rst_state", {31'h0, dbg_state}, {31'h0, IDLE});
        imemREN = 1'b0;
        flush   = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    // Scoreboard monitor: compares each recorded cycle at the falling edge.
    always @(negedge CLK) begin
        logic [66:0] e;
        bit          bad;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            bad = 1'b0;
            n_vec++;
            if (ihit !== e[66]) bad = 1'b1;
            if (e[66] && imemload !== e[65:34]) bad = 1'b1;
            if (iREN !== e[33]) bad = 1'b1;
            if (iaddr !== e[32:1]) bad = 1'b1;
            if ((dbg_state == FETCH) !== e[0]) bad = 1'b1;
            if (bad) begin
                n_err++;
                $display("FAIL cycle @%0t addr=%h: got ihit=%b load=%h iREN=%b iaddr=%h st=%b expected ihit=%b load=%h iREN=%b iaddr=%h st=%b",
                         $time, imemaddr, ihit, imemload, iREN, iaddr, dbg_state,
                         e[66], e[65:34], e[33], e[32:1], e[0]);
            end
        end
    end

    initial begin
        RST      = 1'b1;
        imemREN  = 1'b0;
        imemaddr = '0;
        flush    = 1'b0;
        iwait    = 1'b0;
        iload    = '0;
        model_reset();
        #1;
        check("reset_ihit", {31'h0, ihit}, 32'h0);
        check("reset_iREN", {31'h0, iREN}, 32'h0);
        check("reset_iaddr", iaddr, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Cold miss on 0x40, three busy cycles, then hit on returned word.
        fetch_word(32'h0000_0040, 3, 32'h2008_0001);
        drive(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0000_0040, 1'b0, 1'b0, 32'h0);

        // Same-index conflict: 0x80 evicts 0x40, then 0x40 misses again.
        fetch_word(32'h0000_0080, 1, 32'h1111_0080);
        drive(1'b1, 32'h0000_0080, 1'b0, 1'b0, 32'h0);
        fetch_word(32'h0000_0040, 0, 32'h2222_0040);
        drive(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0);

        // Retargeting during a refill must not disturb it.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'h0);
        drive(1'b1, 32'h0000_0100, 1'b0, 1'b1, 32'h0);
        drive(1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'h3333_0040);
        drive(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0);
        fetch_word(32'h0000_0100, 2, 32'h4444_0100);
        drive(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0);

        // Reset in the middle of a refill; earlier lines must miss afterwards.
        drive(1'b1, 32'h0000_0204, 1'b0, 1'b1, 32'h0);
        drive(1'b1, 32'h0000_0204, 1'b0, 1'b1, 32'h0);
        apply_reset();
        fetch_word(32'h0000_0100, 0, 32'h5555_0100);
        drive(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h0000_0204, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h0000_0204, 1'b0, 0, 32'h6666_0204);

        // Flush during a refill leaves the filled frame invalid.
        apply_reset();
        drive(1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'h0);
        drive(1'b1, 32'h0000_0040, 1'b1, 1'b1, 32'h0);
        drive(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h7777_0040);
        drive(1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'h0);
`ifdef ICACHE_STATS_EN
        @(negedge CLK);
        #1;
        check("miss_count_flush", miss_count, 32'd2);
        check("hit_count_flush", hit_count, 32'd0);
`endif
        drive(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h8888_0040);
        drive(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0);

        // Random traffic over a small pool of colliding addresses.
        for (int n = 0; n < 500; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 6))
                0: a = 32'h0000_0040;
                1: a = 32'h0000_0080;
                2: a = 32'h0000_0100;
                3: a = 32'h0000_0045;
                4: a = 32'h0000_0004;
                5: a = 32'h0000_1008;
                default: a = $urandom & 32'hffff_fffc;
            endcase
            drive($urandom_range(0, 9) < 8, a, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 1) == 1, $urandom);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge CLK);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
`ifdef ICACHE_STATS_EN
        check("hit_count_end", hit_count, m_hits);
        check("miss_count_end", miss_count, m_misses);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
